hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Sequences the 5-stage RISC-V pipeline around hazards that operand forwarding cannot cover.
- Handles three cases: a load-use RAW stall, a branch-taken flush, and a multi-cycle EX hold for mul/div.
- Drives the PC, IF/ID, ID/EX and EX/MEM write/bubble controls.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MD_LATENCY, 4, total cycles a mul/div op occupies EX; legal range 2..255.
- CNT_W, 16, width of StallCount.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  reset, active-low, asynchronous.
- ID_Rs1  input  5  rs1 of the instruction in ID.
- ID_Rs2  input  5  rs2 of the instruction in ID.
- ID_UsesRs1  input  1  the ID instruction reads rs1.
- ID_UsesRs2  input  1  the ID instruction reads rs2.
- EX_MemRead  input  1  the EX instruction is a load.
- EX_rdReg  input  5  rd of the EX instruction.
- EX_IsMulDiv  input  1  the EX instruction is a multi-cycle mul/div.
- BranchTaken  input  1  a branch/jump resolved taken in EX this cycle.
- CountClr  input  1  synchronous clear of StallCount.
- PCWrite  output  1  1 = PC updates.
- IF_ID_Write  output  1  1 = IF/ID register loads.
- IF_ID_Flush  output  1  1 = IF/ID loads a NOP.
- ID_EX_Bubble  output  1  1 = ID/EX loads a NOP (control bits zeroed).
- EX_Hold  output  1  1 = ID/EX holds, EX/MEM loads a NOP.
- StallCount  output  CNT_W  count of cycles with PCWrite=0.

Behaviour:
- State: FSM {RUN, MD_BUSY} plus an 8-bit down-counter md_cnt. Control outputs are combinational from state, md_cnt and inputs.
- Reset (rst_n low, asynchronous):
  - state=RUN, md_cnt=0, StallCount=0.
  - Outputs forced: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, EX_Hold=0, independent of inputs.
- Load-use detection: luse = EX_MemRead & (EX_rdReg!=0) & ((ID_UsesRs1 & EX_rdReg==ID_Rs1) | (ID_UsesRs2 & EX_rdReg==ID_Rs2)).
- RUN, evaluated in this priority order:
  1. EX_IsMulDiv=1:
     - Outputs: EX_Hold=1, PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=0.
     - Next cycle: md_cnt<=MD_LATENCY-2, state<=MD_BUSY.
     - BranchTaken and luse are ignored.
  2. BranchTaken=1:
     - Outputs: PCWrite=1 (redirect target), IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1.
     - Overrides luse.
  3. luse=1:
     - Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
     - Lasts exactly one cycle: the next cycle has a bubble in EX, so luse drops.
  4. Otherwise: all pass-through (PCWrite=1, IF_ID_Write=1, others 0).
- MD_BUSY:
  - md_cnt!=0: EX_Hold=1, PCWrite=0, IF_ID_Write=0; md_cnt decrements.
  - md_cnt==0: release cycle, all pass-through, state<=RUN. The op leaves EX at this edge.
  - BranchTaken and luse are ignored throughout (EX holds the mul/div; no load can be in EX).
  - Net effect: the mul/div occupies EX for exactly MD_LATENCY cycles. With MD_LATENCY=2 the BUSY phase is just the release cycle.
- Back-to-back mul/div:
  - The second op enters EX in the cycle after the release cycle, while state is RUN.
  - It restarts the sequence; there is no gap penalty beyond its own latency.
- StallCount:
  - Increments by 1 every rising edge where PCWrite==0, saturating at all-ones.
  - CountClr=1 clears it to 0 on the next edge; clear wins over increment.
- Reset asserted mid-MD_BUSY: aborts immediately to RUN. Pipeline contents are the surrounding reset's responsibility.
- rd=x0 never creates a load-use stall.

Test Plan:
- Load-use: EX_MemRead=1, EX_rdReg=5, ID_Rs1=5, ID_UsesRs1=1 → one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Then (EX_MemRead=0) all pass-through; StallCount 0→1.
- x0 and unused operands:
  - EX_rdReg=0 with ID_Rs1=0 → no stall.
  - EX_rdReg=7, ID_Rs2=7, ID_UsesRs2=0 → no stall.
- Branch vs load-use same cycle: BranchTaken=1 with luse=1 → IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1; StallCount unchanged.
- Mul/div (MD_LATENCY=4): EX_IsMulDiv=1 held → EX_Hold=1 for cycles 1-3, cycle 4 release. StallCount +3. A BranchTaken pulse in cycle 2 has no effect.
- Reset mid-op: rst_n pulled low in cycle 2 of MD_BUSY → outputs go to reset values asynchronously. After release with EX_IsMulDiv=0: pass-through, StallCount=0.
- Saturation with CNT_W=4: 20 consecutive load-use stalls → StallCount stops at 15. CountClr=1 together with a stall → StallCount=0 next cycle.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Sequences a 5-stage RISC-V pipeline around hazards that forwarding
//   cannot resolve:
//   - a load-use RAW stall
//   - a taken-branch flush
//   - a multi-cycle EX hold for mul/div
//   It also keeps a saturating count of stalled cycles for performance
//   monitoring.
//
// Ports
//   clk, rst_n             pipeline clock, async active-low reset
//   ID_Rs1/ID_Rs2          source registers of the instruction in ID
//   ID_UsesRs1/ID_UsesRs2  the ID instruction actually reads rs1/rs2
//   EX_MemRead, EX_rdReg   the EX instruction is a load, and its rd
//   EX_IsMulDiv            the EX instruction is a multi-cycle mul/div
//   BranchTaken            branch/jump resolved taken in EX this cycle
//   CountClr               synchronous clear of StallCount
//   PCWrite, IF_ID_Write   PC / IF/ID load enables
//   IF_ID_Flush            IF/ID loads a NOP
//   ID_EX_Bubble           ID/EX loads a NOP
//   EX_Hold                ID/EX holds, EX/MEM loads a NOP
//   StallCount             saturating count of cycles with PCWrite=0
//
// state   | meaning
// RUN     | normal issue; decode load-use / branch / mul-div start
// MD_BUSY | mul/div still in EX; md_cnt hold cycles remain before release
module hazard_stall_controller #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_UsesRs1,
  input  logic             ID_UsesRs2,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rdReg,
  input  logic             EX_IsMulDiv,
  input  logic             BranchTaken,
  input  logic             CountClr,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_Hold,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

  // The first hold cycle is spent in RUN and the last cycle is the release,
  // so MD_BUSY only needs MD_LATENCY-2 further hold cycles.
  localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 2);

  state_t     state;
  logic [7:0] md_cnt;
  logic       luse;

  assign luse = EX_MemRead && (EX_rdReg != 5'd0) &&
                ((ID_UsesRs1 && (EX_rdReg == ID_Rs1)) ||
                 (ID_UsesRs2 && (EX_rdReg == ID_Rs2)));

  // Outputs are gated by rst_n so they take their pass-through values
  // the moment reset asserts, not at the next edge.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_Hold      = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (EX_IsMulDiv) begin
            EX_Hold     = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
          end else if (BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
          end else if (luse) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_cnt != 8'd0) begin
            EX_Hold     = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (EX_IsMulDiv) begin
            state  <= MD_BUSY;
            md_cnt <= MD_INIT;
          end
        end
        MD_BUSY: begin
          if (md_cnt != 8'd0) md_cnt <= md_cnt - 8'd1;
          else                state  <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (CountClr) begin
      StallCount <= '0;
    end else if (!PCWrite && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule
